tdc_enabler_mc: RTL

Multi-channel, parametrised successor of the single-channel TDC enabler. It sits between N_CH hit inputs and the per-channel TDC capture/processing chains. For each channel it gates the start (rise) and stop (fall) edges, blocks re-arming until processing ends, and absorbs pile-up hits. Over the single-channel enabler it adds a per-channel arm mask, a single-shot mode with explicit re-arm, a processing timeout watchdog and a saturating pile-up counter.

---
 rtl/tdc_enabler_mc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tdc_enabler_mc.sv
// rtl/tdc_enabler_mc.sv - multi-channel TDC enabler with arm mask, single-shot, watchdog and pile-up count
// One independent gating FSM per channel; edge detection shared across the hit bus.
module tdc_enabler_mc #(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 11,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       hit,
  input  logic [N_CH-1:0]       processing_ended,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  single_shot,
  input  logic                  rearm,
  input  logic                  clr_cnt,
  output logic [N_CH-1:0]       enable,
  output logic [N_CH-1:0]       rise_edge,
  output logic [N_CH-1:0]       fall_edge,
  output logic [N_CH*CNT_W-1:0] pileup_cnt,
  output logic [N_CH-1:0]       timeout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_ARMED     = 3'd1,
    S_RISED     = 3'd2,
    S_BUSY      = 3'd3,
    S_LET_PASS  = 3'd4,
    S_WAIT_FALL = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  logic [N_CH-1:0] hit_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] busy_ch;

  assign rise = hit & ~hit_q;
  assign fall = ~hit & hit_q;
  assign busy = |busy_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d, exit_st;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             inc;
    logic             expire;

    always_comb begin
      exit_st = single_shot ? S_DONE : (ch_en[i] ? S_ARMED : S_RESET);
      expire  = (TIMEOUT != 0) && (timer_q == TMR_W'(1));
      state_d = state_q;
      to_d    = 1'b0;
      inc     = 1'b0;
      case (state_q)
        S_RESET: begin
          if (ch_en[i]) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (!ch_en[i])    state_d = S_RESET;
          else if (rise[i]) state_d = S_RISED;
        end
        S_RISED: begin
          if (fall[i]) state_d = S_BUSY;
        end
        S_BUSY: begin
          if (rise[i]) begin
            state_d = S_LET_PASS;
            inc     = 1'b1;
          end else if (processing_ended[i]) begin
            state_d = exit_st;
          end else if (expire) begin
            state_d = exit_st;
            to_d    = 1'b1;
          end
        end
        S_LET_PASS: begin
          if (processing_ended[i]) begin
            state_d = S_WAIT_FALL;
          end else if (expire) begin
            state_d = S_WAIT_FALL;
            to_d    = 1'b1;
          end else if (fall[i]) begin
            state_d = S_BUSY;
          end
        end
        S_WAIT_FALL: begin
          if (fall[i]) state_d = exit_st;
        end
        S_DONE: begin
          if (rearm) state_d = ch_en[i] ? S_ARMED : S_RESET;
        end
        default: state_d = S_RESET;
      endcase

      // Watchdog is armed on the stop edge; it free-runs down to zero otherwise.
      if (state_q == S_RISED && fall[i]) begin
        timer_d = TMR_W'(TIMEOUT);
      end else if (timer_q != '0) begin
        timer_d = timer_q - TMR_W'(1);
      end else begin
        timer_d = timer_q;
      end

      if (clr_cnt) begin
        cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_RESET;
        timer_q <= '0;
        cnt_q   <= '0;
        to_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        cnt_q   <= cnt_d;
        to_q    <= to_d;
      end
    end

    assign enable[i]                     = (state_q == S_ARMED) || (state_q == S_RISED);
    assign rise_edge[i]                  = rise[i] && (state_q == S_ARMED);
    assign fall_edge[i]                  = fall[i] && ((state_q == S_RISED) || (state_q == S_WAIT_FALL));
    assign timeout[i]                    = to_q;
    assign pileup_cnt[i*CNT_W +: CNT_W]  = cnt_q;
    assign busy_ch[i]                    = (state_q == S_RISED) || (state_q == S_BUSY) ||
                                           (state_q == S_LET_PASS) || (state_q == S_WAIT_FALL);
  end

endmodule
